// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It runs the request-to-send sequence, then shifts out one
// command byte, its parity and the stop bit on device clocks, and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned REQ_CYCLES     = 16,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 10000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_txData,
    input  logic       i_txStart,
    output logic       o_txBusy,
    output logic       o_txDone,
    output logic       o_txError,
    input  logic       i_ps2ClkIn,
    input  logic       i_ps2DataIn,
    output logic       o_ps2ClkOe,
    output logic       o_ps2DataOe
);

    // state     | meaning
    // IDLE      | lines released, waiting for txStart
    // INHIBIT   | clock held low to abort any device transfer
    // REQ       | clock and data low (request-to-send, start bit)
    // SEND      | clock released, data bits follow device falling edges
    // WAIT_IDLE | ACK seen, waiting for both lines high
    // DONE      | one-cycle success pulse
    // ERROR     | one-cycle failure pulse (timeout or no ACK)
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_IDLE, S_DONE, S_ERROR
    } state_t;

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [FW-1:0] r_clk_cnt;
    logic [FW-1:0] r_data_cnt;
    logic          r_clk_filt;
    logic          r_clk_filt_d;
    logic          r_data_filt;
    logic [31:0]   r_timer;
    logic [3:0]    r_edge_cnt;
    logic [8:0]    r_shift;
    logic          r_bit_oe;
    logic          w_fall;
    logic          w_timer_zero;
    logic          w_busy;
    logic          w_done;
    logic          w_error;
    logic          w_clk_oe;
    logic          w_data_oe;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2ClkIn};
            r_data_sync <= {r_data_sync[0], i_ps2DataIn};
        end
    end

    // A filtered line only changes after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_clk_cnt    <= '0;
            r_data_filt  <= 1'b1;
            r_data_cnt   <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_clk_cnt  <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (r_data_sync[1] == r_data_filt) begin
                r_data_cnt <= '0;
            end else if (r_data_cnt == FW'(FILTER_LEN - 1)) begin
                r_data_filt <= r_data_sync[1];
                r_data_cnt  <= '0;
            end else begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end
    end

    assign w_fall       = r_clk_filt_d & ~r_clk_filt;
    assign w_timer_zero = (r_timer == 32'd0);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_clk_oe    = 1'b0;
        w_data_oe   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_txStart) w_state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                w_busy   = 1'b1;
                w_clk_oe = 1'b1;
                if (w_timer_zero) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_busy    = 1'b1;
                w_clk_oe  = 1'b1;
                w_data_oe = 1'b1;
                if (w_timer_zero) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_busy    = 1'b1;
                w_data_oe = r_bit_oe;
                if (w_fall) begin
                    if (r_edge_cnt == 4'd10) begin
                        w_state_nxt = r_data_filt ? S_ERROR : S_WAIT_IDLE;
                    end
                end else if (w_timer_zero) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_WAIT_IDLE: begin
                w_busy = 1'b1;
                if (r_clk_filt && r_data_filt) begin
                    w_state_nxt = S_DONE;
                end else if (w_timer_zero) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERROR: begin
                w_error     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The shift register refills with ones, so the edge after parity naturally releases data (stop bit).
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_timer    <= 32'd0;
            r_edge_cnt <= 4'd0;
            r_shift    <= 9'h1FF;
            r_bit_oe   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_txStart) begin
                        r_shift <= {~^i_txData, i_txData};
                        r_timer <= INHIBIT_CYCLES - 32'd1;
                    end
                end
                S_INHIBIT: begin
                    if (w_timer_zero) r_timer <= REQ_CYCLES - 32'd1;
                    else              r_timer <= r_timer - 32'd1;
                end
                S_REQ: begin
                    r_edge_cnt <= 4'd0;
                    r_bit_oe   <= 1'b1;
                    if (w_timer_zero) r_timer <= START_TIMEOUT - 32'd1;
                    else              r_timer <= r_timer - 32'd1;
                end
                S_SEND: begin
                    if (w_fall) begin
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        r_timer    <= BIT_TIMEOUT - 32'd1;
                        r_bit_oe   <= ~r_shift[0];
                        r_shift    <= {1'b1, r_shift[8:1]};
                    end else if (!w_timer_zero) begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!w_timer_zero) r_timer <= r_timer - 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_txBusy    = w_busy;
    assign o_txDone    = w_done;
    assign o_txError   = w_error;
    assign o_ps2ClkOe  = w_clk_oe;
    assign o_ps2DataOe = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a modelled device clocks frames from a vector table,
// followed by hand sequences for reset, request timing and the start timeout.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy, done, err, clk_oe, data_oe;
    logic       dev_clk, dev_data;
    logic       pin_clk, pin_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;

    assign pin_clk  = dev_clk & ~clk_oe;
    assign pin_data = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .REQ_CYCLES    (16),
        .START_TIMEOUT (1000),
        .BIT_TIMEOUT   (400),
        .FILTER_LEN    (4)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_txData   (tx_data),
        .i_txStart  (tx_start),
        .o_txBusy   (busy),
        .o_txDone   (done),
        .o_txError  (err),
        .i_ps2ClkIn (pin_clk),
        .i_ps2DataIn(pin_data),
        .o_ps2ClkOe (clk_oe),
        .o_ps2DataOe(data_oe)
    );

    always @(negedge clk) begin
        if (done)        n_done <= n_done + 1;
        if (err)         n_err  <= n_err + 1;
        if (done && err) n_both <= n_both + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       glitch;
        logic       mid_start;
        logic       rst5;
        logic [9:0] exp_oe;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int  d0, e0;
        bit  ok;
        d0 = n_done;
        e0 = n_err;
        @(negedge clk);
        tx_data  = v.data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!clk_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("release_%0d", idx), int'(ok), 1);
        if (ok) begin
            for (int k = 1; k <= 11; k++) begin
                for (int i = 0; i < 15; i++) begin
                    @(negedge clk);
                    if (k == 4 && v.glitch && i == 8)  dev_clk = 1'b0;
                    if (k == 4 && v.glitch && i == 10) dev_clk = 1'b1;
                    if (k == 11 && i == 2)             dev_data = v.ack;
                end
                dev_clk = 1'b0;
                repeat (12) @(negedge clk);
                if (k <= 10)
                    chk($sformatf("oe_%0d_edge%0d", idx, k), int'(data_oe), int'(v.exp_oe[k-1]));
                if (k == 5 && v.rst5) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk($sformatf("rst_clkoe_%0d", idx), int'(clk_oe), 0);
                    chk($sformatf("rst_dataoe_%0d", idx), int'(data_oe), 0);
                    chk($sformatf("rst_busy_%0d", idx), int'(busy), 0);
                    dev_clk = 1'b1;
                    repeat (5) @(negedge clk);
                    rst_n = 1'b1;
                    break;
                end
                if (k == 5 && v.mid_start) begin
                    tx_start = 1'b1;
                    tx_data  = ~v.data;
                    @(negedge clk);
                    tx_start = 1'b0;
                end
                repeat (8) @(negedge clk);
                dev_clk = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        dev_data = 1'b1;
        dev_clk  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("idle_%0d", idx), int'(ok), 1);
        repeat (40) @(negedge clk);
        chk($sformatf("done_cnt_%0d", idx), n_done - d0, int'(v.exp_done));
        chk($sformatf("err_cnt_%0d", idx), n_err - e0, int'(v.exp_err));
        chk($sformatf("end_oe_%0d", idx), int'({clk_oe, data_oe}), 0);
    endtask

    initial begin
        int clk_oe_cnt, first_data, clk_fall, err_at, oe_at_err;
        bit done_seen;

        //            data   ack  glt  mid  rst  exp_oe   done err
        vecs[0] = '{8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, 10'h10B, 1'b1, 1'b0};
        vecs[1] = '{8'hED, 1'b0, 1'b0, 1'b0, 1'b0, 10'h012, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0FF, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 10'h05A, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0C3, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1FE, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 10'h17F, 1'b1, 1'b0};

        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy",   int'(busy),    0);
        chk("reset_done",   int'(done),    0);
        chk("reset_err",    int'(err),     0);
        chk("reset_clkoe",  int'(clk_oe),  0);
        chk("reset_dataoe", int'(data_oe), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Request timing, then start timeout with a silent device.
        clk_oe_cnt = 0; first_data = 0; clk_fall = 0; err_at = 0; oe_at_err = -1; done_seen = 1'b0;
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 1; c <= 1200; c++) begin
            if (clk_oe) clk_oe_cnt++;
            if (data_oe && first_data == 0) first_data = c;
            if (!clk_oe && clk_fall == 0) clk_fall = c;
            if (err && err_at == 0) begin
                err_at    = c;
                oe_at_err = int'({clk_oe, data_oe});
            end
            if (done) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("clkoe_cycles",   clk_oe_cnt, 116);
        chk("dataoe_rise",    first_data, 101);
        chk("clkoe_fall",     clk_fall,   117);
        chk("start_timeout",  err_at,     1117);
        chk("oe_at_error",    oe_at_err,  0);
        chk("no_done_on_err", int'(done_seen), 0);
        chk("busy_after_err", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

        chk("done_err_overlap", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
